// File: rtl/multicycle_memory_responder_pkg.sv
// Shared encodings, default bases and FSM states for the memory responder.
// Latency: none (declarations only).
// Backpressure: none.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] DEF_TEXT_BASE = 32'h0040_0000;
    localparam logic [31:0] DEF_DATA_BASE = 32'h1001_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size code 3 has no legal alignment, so it reports misaligned as well.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return addr_lo != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_memory_responder_if.sv
// Datapath-to-memory request/response bundle.
// Latency: none (wiring only).
// Backpressure: oBusy high while a request is in flight; strobes are then ignored.
interface multicycle_memory_responder_if;

    logic        read;
    logic        write;
    logic [31:0] iAddress;
    logic [31:0] iData;
    logic [1:0]  iSize;
    logic        iUnsigned;
    logic [31:0] oData;
    logic        oReady;
    logic        oError;
    logic        oBusy;

    modport master (
        output read, write, iAddress, iData, iSize, iUnsigned,
        input  oData, oReady, oError, oBusy
    );

    modport slave (
        input  read, write, iAddress, iData, iSize, iUnsigned,
        output oData, oReady, oError, oBusy
    );

endinterface

// File: rtl/multicycle_memory_responder_lane_align.sv
// Byte-lane steering: store enables/replicated data and load extract/extend.
// Latency: combinational.
// Backpressure: none.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    // Store data is replicated across lanes; the byte enables pick the live one.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        o_rdata = i_rword;
        case (i_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SIZE_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            end
            SIZE_WORD: begin
                o_be = 4'b1111;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_memory_responder.sv
// Single-outstanding load/store responder over text and data word arrays.
// Latency: oReady WAIT_STATES+1 cycles after the accepting cycle, for one cycle.
// Backpressure: oBusy from acceptance through oReady; strobes outside IDLE are dropped.
module multicycle_memory_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE   = DEF_TEXT_BASE,
    parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
    parameter int          WORDS       = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    multicycle_memory_responder_if.slave  bus
);

    localparam int          AW       = $clog2(WORDS);
    localparam logic [31:0] SPAN     = 32'(WORDS * 4);
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_odata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_write;
    logic        r_err;
    logic        r_text;

    logic [31:0] r_text_mem [WORDS];
    logic [31:0] r_data_mem [WORDS];

    logic          w_accept;
    logic          w_live;
    logic          w_commit;
    logic          w_in_text;
    logic          w_in_data;
    logic          w_in_err;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [1:0]    w_size;
    logic          w_unsigned;
    logic          w_write;
    logic          w_err;
    logic          w_text;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_st_data;
    logic [31:0]   w_ld_data;
    logic          w_we_text;
    logic          w_we_data;

    assign w_accept  = (r_state == ST_IDLE) && (bus.read || bus.write);
    assign w_in_text = (bus.iAddress - TEXT_BASE) < SPAN;
    assign w_in_data = (bus.iAddress - DATA_BASE) < SPAN;
    assign w_in_err  = (bus.read && bus.write)
                     || misaligned(bus.iSize, bus.iAddress[1:0])
                     || !(w_in_text || w_in_data);

    // With zero wait states the access lands on the accepting edge, so the
    // live inputs stand in for the not-yet-latched request.
    assign w_live     = (r_state == ST_IDLE);
    assign w_addr     = w_live ? bus.iAddress  : r_addr;
    assign w_wdata    = w_live ? bus.iData     : r_wdata;
    assign w_size     = w_live ? bus.iSize     : r_size;
    assign w_unsigned = w_live ? bus.iUnsigned : r_unsigned;
    assign w_write    = w_live ? bus.write     : r_write;
    assign w_err      = w_live ? w_in_err      : r_err;
    assign w_text     = w_live ? w_in_text     : r_text;

    assign w_off   = w_addr - (w_text ? TEXT_BASE : DATA_BASE);
    assign w_idx   = AW'(w_off >> 2);
    assign w_rword = w_text ? r_text_mem[w_idx] : r_data_mem[w_idx];

    mem_lane_align u_lane_align (
        .i_addr_lo  (w_addr[1:0]),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .i_wdata    (w_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wdata    (w_st_data),
        .o_rdata    (w_ld_data)
    );

    assign w_commit  = (w_next == ST_RESP) && (r_state != ST_RESP);
    assign w_we_text = w_commit && !reset && w_write && !w_err && w_text;
    assign w_we_data = w_commit && !reset && w_write && !w_err && !w_text;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_odata    <= 32'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_size     <= SIZE_BYTE;
            r_unsigned <= 1'b0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_text     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt      <= CNT_LOAD;
                r_addr     <= bus.iAddress;
                r_wdata    <= bus.iData;
                r_size     <= bus.iSize;
                r_unsigned <= bus.iUnsigned;
                r_write    <= bus.write;
                r_err      <= w_in_err;
                r_text     <= w_in_text;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_write && !w_err) begin
                r_odata <= w_ld_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we_text && w_be[b]) r_text_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
    end

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we_data && w_be[b]) r_data_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
        end
    end

    assign bus.oData  = r_odata;
    assign bus.oReady = (r_state == ST_RESP);
    assign bus.oError = (r_state == ST_RESP) && r_err;
    assign bus.oBusy  = (r_state != ST_IDLE);

endmodule
